// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-memory bus bundle for instr_encoder
//
// Purpose : groups the instruction request handshake/fields and the
//           instruction-memory write bus into one interface.
// Signals : in_valid/in_ready        request handshake
//           in_op                    mnemonic code (0..13 supported)
//           in_rs/in_rt/in_rd/in_shamt, in_funct, in_imm, in_target  fields
//           mem_we/mem_addr/mem_wdata  write strobe, word address, word
//           mem_ready                memory has taken the write
// Modports: master = request source / memory side, slave = encoder side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes MIPS-style instruction requests and writes them to instruction memory
//
// Purpose : accepts one instruction request at a time, encodes it into a
//           32-bit word and writes it to consecutive memory words starting
//           at address 0. After writing address 255 it stops in FULL until
//           clear. Unsupported ops (14, 15) are swallowed and flag err_unsup.
// Ports   : clk          rising-edge clock
//           rst_n        asynchronous active-low reset
//           clear        synchronous restart, beats every other event
//           bus          instr_encoder_if.slave (request + memory bus)
//           full         all 256 words written
//           err_unsup    sticky: an unsupported op was seen
//           instr_count  completed writes (saturating)
// Config  : ENC_COUNT_EN - when defined, instr_count is a live counter;
//           otherwise it is tied to zero and no counter register exists.
module instr_encoder (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  instr_encoder_if.slave  bus,
  output logic            full,
  output logic            err_unsup,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic        in_ready_c;
  logic        mem_we_c;
  logic        full_c;
  logic        accept;
  logic        write_done;

  logic        supported;
  logic [5:0]  opcode;
  logic [31:0] enc_word;

  // Opcode lookup; ops 14 and 15 fall through as unsupported.
  always_comb begin
    opcode    = 6'b000000;
    supported = 1'b1;
    case (bus.in_op)
      4'd0:    opcode = 6'b000000;  // R
      4'd1:    opcode = 6'b000010;  // J
      4'd2:    opcode = 6'b000011;  // JAL
      4'd3:    opcode = 6'b000100;  // BEQ
      4'd4:    opcode = 6'b000101;  // BNE
      4'd5:    opcode = 6'b001000;  // ADDI
      4'd6:    opcode = 6'b001010;  // SLTI
      4'd7:    opcode = 6'b001011;  // SLTIU
      4'd8:    opcode = 6'b001100;  // ANDI
      4'd9:    opcode = 6'b001101;  // ORI
      4'd10:   opcode = 6'b001110;  // XORI
      4'd11:   opcode = 6'b001111;  // LUI
      4'd12:   opcode = 6'b100011;  // LW
      4'd13:   opcode = 6'b101011;  // SW
      default: supported = 1'b0;
    endcase
  end

  // Word formats: R, J-type and I-type. LUI has no source register, so
  // its rs field is zeroed regardless of what the requester supplied.
  always_comb begin
    enc_word = 32'd0;
    case (bus.in_op)
      4'd0:       enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_rd,
                              bus.in_shamt, bus.in_funct};
      4'd1, 4'd2: enc_word = {opcode, bus.in_target};
      4'd11:      enc_word = {opcode, 5'b00000, bus.in_rt, bus.in_imm};
      default:    enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_imm};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. accept/write_done are gated by clear
  // so a restart pulse wins over a request or a memory acknowledge landing
  // on the same edge.
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    mem_we_c   = 1'b0;
    full_c     = 1'b0;
    accept     = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        accept     = bus.in_valid && !clear;
        if (accept && supported) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_we_c   = 1'b1;
        write_done = bus.mem_ready && !clear;
        if (write_done) begin
          state_nxt = (addr_q == 8'hFF) ? FULL : IDLE;
        end
      end
      FULL: begin
        full_c = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (clear) begin
      addr_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept && supported) begin
        wdata_q <= enc_word;
      end
      if (accept && !supported) begin
        err_q <= 1'b1;
      end
      // The last word keeps its address; FULL is the only way out.
      if (write_done && (addr_q != 8'hFF)) begin
        addr_q <= addr_q + 8'd1;
      end
    end
  end

`ifdef ENC_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else if (clear) begin
      count_q <= 16'd0;
    end else if (write_done && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = 16'd0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign full          = full_c;
  assign err_unsup     = err_q;

endmodule
